// File: rtl/bp_me_stream_pump_out.sv
// Outbound stream pump: turns producer-FSM header/data beats into BedRock stream beats
// (1:1, N:1 or 1:N by msg_type masks) through a two-entry output buffer.
// Header layout (LSB first): msg_type[3:0], addr[paddr_width_p], size[2:0], payload.
module bp_me_stream_pump_out
  #(parameter int paddr_width_p = 40
  , parameter int stream_data_width_p = 64
  , parameter int block_width_p = 512
  , parameter int payload_width_p = 32
  , parameter logic [15:0] msg_stream_mask_p = '0
  , parameter logic [15:0] fsm_stream_mask_p = msg_stream_mask_p
  , localparam int header_width = payload_width_p + 3 + paddr_width_p + 4
  , localparam int stream_words = block_width_p / stream_data_width_p
  , localparam int cnt_w = (stream_words > 1) ? $clog2(stream_words) : 1
  )
  (input  logic                           clk_i
  , input  logic                          reset_i
  , input  logic [header_width-1:0]       fsm_header_i
  , input  logic [stream_data_width_p-1:0] fsm_data_i
  , input  logic                          fsm_v_i
  , output logic                          fsm_ready_and_o
  , output logic [cnt_w-1:0]              fsm_cnt_o
  , output logic                          fsm_new_o
  , output logic                          fsm_last_o
  , output logic [header_width-1:0]       msg_header_o
  , output logic [stream_data_width_p-1:0] msg_data_o
  , output logic                          msg_v_o
  , output logic                          msg_last_o
  , input  logic                          msg_ready_and_i
  );

  localparam int stream_bytes = stream_data_width_p / 8;
  localparam int offset_w = (stream_bytes > 1) ? $clog2(stream_bytes) : 1;
  localparam int entry_w = header_width + stream_data_width_p + 1;

  typedef enum logic {e_idle, e_busy} state_e;

  state_e state_reg, state_next;
  logic [cnt_w-1:0] cnt_reg, cnt_next;
  logic [cnt_w-1:0] step_reg, step_next;

  logic [3:0] msg_type;
  logic [31:0] size_ext;
  logic [cnt_w-1:0] stream_size, first_cnt, counted_size, cur_cnt, cur_step;
  logic nz, fsm_stream, msg_stream, mode_n1, mode_1n;
  logic buf_ready, advance, enq, deq;

  logic [entry_w-1:0] mem_reg [2];
  logic [entry_w-1:0] rd_entry;
  logic wr_ptr_reg, rd_ptr_reg;
  logic [1:0] count_reg, count_next;

  assign msg_type = fsm_header_i[3:0];
  assign size_ext = 32'(fsm_header_i[4+paddr_width_p +: 3]);
  assign first_cnt = fsm_header_i[4+offset_w +: cnt_w];

  // Beats per message minus one; sizes at or below one beat collapse to a single beat.
  assign stream_size = (size_ext > 32'(offset_w))
                     ? cnt_w'((32'd1 << (size_ext - 32'(offset_w))) - 32'd1)
                     : '0;
  assign nz = (stream_size != '0);
  assign fsm_stream = fsm_stream_mask_p[msg_type] & nz;
  assign msg_stream = msg_stream_mask_p[msg_type] & nz;
  assign mode_n1 = fsm_stream & ~msg_stream;
  assign mode_1n = msg_stream & ~fsm_stream;
  assign counted_size = (fsm_stream | msg_stream) ? stream_size : '0;

  assign cur_cnt = (state_reg == e_busy) ? cnt_reg : first_cnt;
  assign cur_step = (state_reg == e_busy) ? step_reg : '0;

  assign fsm_cnt_o = cur_cnt;
  assign fsm_new_o = (state_reg == e_idle);
  assign fsm_last_o = (cur_step == counted_size);

  // Only a free slot counts as ready: no enqueue-on-dequeue when full, so no path from msg_ready.
  assign buf_ready = (count_reg != 2'd2);
  assign fsm_ready_and_o = buf_ready & (~mode_1n | fsm_last_o);
  assign advance = fsm_v_i & buf_ready;
  assign enq = advance & (~mode_n1 | fsm_last_o);
  assign deq = msg_v_o & msg_ready_and_i;

  always_comb begin
    state_next = state_reg;
    cnt_next = cnt_reg;
    step_next = step_reg;
    if (advance) begin
      if (fsm_last_o) begin
        state_next = e_idle;
      end else begin
        state_next = e_busy;
        cnt_next = (cur_cnt == cnt_w'(stream_words - 1)) ? '0 : cur_cnt + 1'b1;
        step_next = cur_step + 1'b1;
      end
    end
  end

  always_comb begin
    count_next = count_reg;
    if (enq && !deq) count_next = count_reg + 2'd1;
    else if (!enq && deq) count_next = count_reg - 2'd1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg <= e_idle;
      cnt_reg <= '0;
      step_reg <= '0;
      count_reg <= '0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg <= cnt_next;
      step_reg <= step_next;
      count_reg <= count_next;
      if (enq) wr_ptr_reg <= ~wr_ptr_reg;
      if (deq) rd_ptr_reg <= ~rd_ptr_reg;
    end
  end

  // The incoming header already carries the critical-word address and is stable per message.
  always_ff @(posedge clk_i) begin
    if (enq) mem_reg[wr_ptr_reg] <= {fsm_header_i, fsm_data_i, fsm_last_o};
  end

  assign rd_entry = mem_reg[rd_ptr_reg];
  assign msg_v_o = (count_reg != 2'd0);
  assign msg_header_o = rd_entry[entry_w-1 -: header_width];
  assign msg_data_o = rd_entry[stream_data_width_p:1];
  assign msg_last_o = msg_v_o & rd_entry[0];

endmodule

// File: tb/tb_bp_me_stream_pump_out.sv
// Self-checking bench for bp_me_stream_pump_out: idle-output vector table, directed
// multi-cycle sequences and randomized messages against a message-level scoreboard.
module tb_bp_me_stream_pump_out;

  localparam int PW = 16;
  localparam int PAYW = 8;
  localparam int HW = PAYW + 3 + PW + 4;
  localparam logic [15:0] MSG_MASK = 16'b1010;
  localparam logic [15:0] FSM_MASK = 16'b0110;

  logic clk, reset_i;
  logic [HW-1:0] fsm_header;
  logic [63:0] fsm_data;
  logic fsm_v, fsm_ready_and_o, fsm_new_o, fsm_last_o;
  logic [2:0] fsm_cnt_o;
  logic [HW-1:0] msg_header_o;
  logic [63:0] msg_data_o;
  logic msg_v_o, msg_last_o, msg_ready;

  int checks = 0;
  int errors = 0;
  bit ready_force = 1;
  bit ready_val = 1;

  typedef struct {
    logic [HW-1:0] hdr;
    logic [63:0] data;
    logic last;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  typedef struct {
    logic [3:0] typ;
    logic [2:0] size;
    logic [15:0] addr;
    logic [2:0] exp_cnt;
    logic exp_new;
    logic exp_last;
  } vec_t;

  bp_me_stream_pump_out #(
    .paddr_width_p(PW), .stream_data_width_p(64), .block_width_p(512),
    .payload_width_p(PAYW), .msg_stream_mask_p(MSG_MASK), .fsm_stream_mask_p(FSM_MASK)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .fsm_header_i(fsm_header), .fsm_data_i(fsm_data), .fsm_v_i(fsm_v),
    .fsm_ready_and_o(fsm_ready_and_o), .fsm_cnt_o(fsm_cnt_o),
    .fsm_new_o(fsm_new_o), .fsm_last_o(fsm_last_o),
    .msg_header_o(msg_header_o), .msg_data_o(msg_data_o),
    .msg_v_o(msg_v_o), .msg_last_o(msg_last_o), .msg_ready_and_i(msg_ready)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic logic [HW-1:0] mk_hdr(input logic [3:0] t, input logic [2:0] s,
                                            input logic [15:0] a, input logic [7:0] p);
    return {p, s, a, t};
  endfunction

  // Beats per message minus one, from the byte size and 8-byte beats.
  function automatic int stream_size_of(input logic [2:0] s);
    int bytes, beats;
    bytes = 1 << s;
    beats = bytes / 8;
    if (beats < 1) beats = 1;
    return (beats - 1) % 8;
  endfunction

  initial begin
    msg_ready = 1;
    forever begin
      @(posedge clk);
      #1;
      msg_ready = ready_force ? ready_val : ($urandom_range(0, 3) != 0);
    end
  end

  always @(negedge clk) begin
    if (!reset_i && msg_v_o && msg_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got data %h, required no beat", msg_data_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk("msg_header", 64'(msg_header_o), 64'(mon_e.hdr));
        chk("msg_data", msg_data_o, mon_e.data);
        chk("msg_last", 64'(msg_last_o), 64'(mon_e.last));
      end
    end
  end

  // Presents one beat and returns at the negedge before the accepting posedge.
  task automatic drive_beat(input logic [HW-1:0] h, input logic [63:0] d, output int waits);
    fsm_header = h;
    fsm_data = d;
    fsm_v = 1;
    waits = 0;
    @(negedge clk);
    while (!fsm_ready_and_o && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 200) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no fsm_ready_and_o, required acceptance");
    end
  endtask

  task automatic send_msg(input logic [HW-1:0] h, input int gap_max, output int last_waits);
    logic [3:0] t;
    logic [2:0] s;
    int ss, n, nf, first, kk, w, g;
    bit fs, ms;
    logic [63:0] d[$];
    t = h[3:0];
    s = h[4+PW +: 3];
    ss = stream_size_of(s);
    n = ss + 1;
    fs = FSM_MASK[t] && (ss != 0);
    ms = MSG_MASK[t] && (ss != 0);
    first = (h[4 +: PW] >> 3) % 8;
    nf = fs ? n : 1;
    for (int k = 0; k < nf; k++) d.push_back({$urandom(), $urandom()});
    if (fs == ms) begin
      for (int k = 0; k < nf; k++) exp_q.push_back('{h, d[k], k == nf - 1});
    end else if (fs) begin
      exp_q.push_back('{h, d[nf-1], 1'b1});
    end else begin
      for (int k = 0; k < n; k++) exp_q.push_back('{h, d[0], k == n - 1});
    end
    $display("msg hdr=%h type=%0d size=%0d fsm_beats=%0d msg_beats=%0d", h, t, s, nf, ms ? n : (fs ? 1 : nf));
    w = 0;
    for (int k = 0; k < nf; k++) begin
      drive_beat(h, d[k], w);
      kk = fs ? k : (ms ? n - 1 : 0);
      chk("fsm_cnt", 64'(fsm_cnt_o), 64'((first + kk) % 8));
      chk("fsm_new", 64'(fsm_new_o), 64'(kk == 0));
      chk("fsm_last", 64'(fsm_last_o), 64'(fs ? (k == nf - 1) : 1));
      @(posedge clk);
      #1;
      fsm_v = 0;
      g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
      repeat (g) begin
        @(posedge clk);
        #1;
      end
    end
    last_waits = w;
  endtask

  task automatic drain();
    int c = 0;
    while (exp_q.size() != 0 && c < 500) begin
      @(negedge clk);
      c++;
    end
    chk("drain_remaining", 64'(exp_q.size()), 64'd0);
  endtask

  vec_t vecs[8];
  int w;

  initial begin
    vecs[0] = '{4'd0, 3'd3, 16'h0010, 3'd2, 1'b1, 1'b1};
    vecs[1] = '{4'd1, 3'd6, 16'h0010, 3'd2, 1'b1, 1'b0};
    vecs[2] = '{4'd1, 3'd3, 16'h0028, 3'd5, 1'b1, 1'b1};
    vecs[3] = '{4'd2, 3'd6, 16'h0038, 3'd7, 1'b1, 1'b0};
    vecs[4] = '{4'd3, 3'd5, 16'h0000, 3'd0, 1'b1, 1'b0};
    vecs[5] = '{4'd0, 3'd6, 16'h0018, 3'd3, 1'b1, 1'b1};
    vecs[6] = '{4'd1, 3'd7, 16'h1FF8, 3'd7, 1'b1, 1'b0};
    vecs[7] = '{4'd2, 3'd2, 16'h0008, 3'd1, 1'b1, 1'b1};

    reset_i = 1;
    fsm_v = 0;
    fsm_header = '0;
    fsm_data = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_i = 0;
    @(negedge clk);
    chk("reset_msg_v", 64'(msg_v_o), 64'd0);
    chk("reset_msg_last", 64'(msg_last_o), 64'd0);
    chk("reset_fsm_new", 64'(fsm_new_o), 64'd1);
    chk("reset_fsm_ready", 64'(fsm_ready_and_o), 64'd1);

    // Idle outputs follow the presented header
    for (int i = 0; i < 8; i++) begin
      fsm_header = mk_hdr(vecs[i].typ, vecs[i].size, vecs[i].addr, 8'h5A);
      @(negedge clk);
      chk("idle_cnt", 64'(fsm_cnt_o), 64'(vecs[i].exp_cnt));
      chk("idle_new", 64'(fsm_new_o), 64'(vecs[i].exp_new));
      chk("idle_last", 64'(fsm_last_o), 64'(vecs[i].exp_last));
      $display("vec %0d type=%0d size=%0d addr=%h cnt=%0d last=%0d", i, vecs[i].typ,
               vecs[i].size, vecs[i].addr, fsm_cnt_o, fsm_last_o);
    end
    @(posedge clk);
    #1;

    // 1:1 single beat and one-cycle latency
    send_msg(mk_hdr(4'd0, 3'd3, 16'h0010, 8'h11), 0, w);
    @(negedge clk);
    chk("latency_msg_v", 64'(msg_v_o), 64'd1);
    drain();
    @(posedge clk);
    #1;

    send_msg(mk_hdr(4'd1, 3'd6, 16'h0010, 8'h22), 0, w);  // 1:1 stream, cnt 2..7,0,1
    send_msg(mk_hdr(4'd1, 3'd6, 16'h0028, 8'h33), 0, w);  // wrap from 5
    send_msg(mk_hdr(4'd2, 3'd6, 16'h0000, 8'h44), 0, w);  // N:1
    drain();
    @(posedge clk);
    #1;
    send_msg(mk_hdr(4'd3, 3'd6, 16'h0000, 8'h55), 0, w);  // 1:N
    chk("one_to_n_ready_wait", 64'(w), 64'd7);
    drain();

    // Backpressure during a 1:1 stream
    @(negedge clk);
    ready_val = 0;
    @(posedge clk);
    #1;
    fork
      begin
        int wb;
        send_msg(mk_hdr(4'd1, 3'd6, 16'h0008, 8'h66), 0, wb);
      end
      begin
        repeat (4) @(negedge clk);
        chk("bp_fsm_ready", 64'(fsm_ready_and_o), 64'd0);
        chk("bp_msg_v", 64'(msg_v_o), 64'd1);
        @(negedge clk);
        ready_val = 1;
      end
    join
    drain();

    // Reset in the middle of a message
    @(negedge clk);
    ready_val = 0;
    @(posedge clk);
    #1;
    fsm_header = mk_hdr(4'd1, 3'd6, 16'h0000, 8'h77);
    fsm_v = 1;
    for (int k = 0; k < 3; k++) begin
      fsm_data = {32'hDEAD0000, 32'(k)};
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("midrst_full_ready", 64'(fsm_ready_and_o), 64'd0);
    @(posedge clk);
    #1;
    reset_i = 1;
    @(posedge clk);
    #1;
    reset_i = 0;
    fsm_v = 0;
    @(negedge clk);
    chk("midrst_msg_v", 64'(msg_v_o), 64'd0);
    chk("midrst_fsm_new", 64'(fsm_new_o), 64'd1);
    chk("midrst_fsm_ready", 64'(fsm_ready_and_o), 64'd1);
    ready_val = 1;
    @(posedge clk);
    #1;
    send_msg(mk_hdr(4'd0, 3'd3, 16'h0020, 8'h88), 0, w);
    drain();

    // Randomized messages with random backpressure
    @(negedge clk);
    ready_force = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 40; i++) begin
      send_msg(mk_hdr(4'($urandom_range(0, 5)), 3'($urandom_range(0, 7)),
                      16'($urandom()), 8'($urandom())), 2, w);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
